// File: rtl/limber_gnrl_pipe_skid.sv
// Two-entry valid/ready skid buffer. The main register drives the downstream
// payload and the skid register catches the one extra item accepted while
// downstream stalls. i_rdy is derived from registered state (plus flush), so
// there is no combinational path from o_rdy to i_rdy.
module limber_gnrl_pipe_skid #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [1:0]    o_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_main = '0;
  logic [DW-1:0]   r_skid = '0;
  logic            w_in_hs;
  logic            w_out_hs;
  logic            w_main_lden;
  logic            w_skid_lden;

  assign i_rdy    = (r_state != ST_FULL) & ~flush;
  assign o_vld    = (r_state != ST_EMPTY);
  assign o_dat    = r_main;
  assign w_in_hs  = i_vld & i_rdy;
  assign w_out_hs = o_vld & o_rdy;

  // Occupancy decode from the state register.
  always_comb begin
    o_cnt = 2'd0;
    case (r_state)
      ST_BUSY: o_cnt = 2'd1;
      ST_FULL: o_cnt = 2'd2;
      default: o_cnt = 2'd0;
    endcase
  end

  // Next-state and load-enable generation; flush forces EMPTY.
  always_comb begin
    w_state_nxt = r_state;
    w_main_lden = 1'b0;
    w_skid_lden = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_hs) begin
          w_main_lden = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in_hs && w_out_hs) begin
          w_main_lden = 1'b1;
        end else if (w_in_hs) begin
          w_skid_lden = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out_hs) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_hs) begin
          w_main_lden = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main register: refilled from upstream, or from skid when draining FULL.
  always_ff @(posedge clk) begin
    if (w_main_lden) begin
      r_main <= (r_state == ST_FULL) ? r_skid : i_dat;
    end
  end

  // Skid register: catches the item accepted while the main entry stalls.
  always_ff @(posedge clk) begin
    if (w_skid_lden) begin
      r_skid <= i_dat;
    end
  end

endmodule

// File: tb/tb_limber_gnrl_pipe_skid.sv
// Bench for limber_gnrl_pipe_skid: directed vector table, streaming loop,
// and randomized traffic against a queue-based reference model.
module tb_limber_gnrl_pipe_skid;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       i_vld;
  logic       i_rdy;
  logic [7:0] i_dat;
  logic       o_vld;
  logic       o_rdy;
  logic [7:0] o_dat;
  logic [1:0] o_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  logic       last_iv   = 1'b0;
  logic       last_in_hs = 1'b0;

  typedef struct {
    logic       rn;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ev;
    logic       er;
    logic [1:0] ec;
    logic [7:0] ed;
  } vec_t;

  vec_t tv[19];

  limber_gnrl_pipe_skid #(.DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_cnt (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rn, input logic fl, input logic iv,
                              input logic [7:0] id, input logic ordy, input logic ev,
                              input logic er, input logic [1:0] ec, input logic [7:0] ed);
    vec_t v;
    v.rn = rn; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ev = ev; v.er = er; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  // One clock cycle: drive, check against model (and optional explicit
  // expectations) mid-cycle, advance the model at the edge.
  task automatic step(input logic rn, input logic fl, input logic iv, input logic [7:0] id,
                      input logic ordy, input logic en_chk,
                      input logic e_en, input logic ev, input logic er,
                      input logic [1:0] ec, input logic [7:0] ed);
    logic       m_vld, m_rdy, hs_in, hs_out, hold;
    logic [7:0] hdat;
    rst_n = rn; flush = fl; i_vld = iv; i_dat = id; o_rdy = ordy;
    #1;
    m_vld = (q.size() > 0);
    m_rdy = (q.size() < 2) && !fl;
    hdat  = m_vld ? q[0] : 8'h00;
    if (en_chk) begin
      chk("model_o_vld", {7'b0, o_vld}, {7'b0, m_vld});
      chk("model_i_rdy", {7'b0, i_rdy}, {7'b0, m_rdy});
      chk("model_o_cnt", {6'b0, o_cnt}, q.size() > 2 ? 8'hff : 8'(q.size()));
      if (m_vld) chk("model_o_dat", o_dat, hdat);
    end
    if (e_en) begin
      chk("vec_o_vld", {7'b0, o_vld}, {7'b0, ev});
      chk("vec_i_rdy", {7'b0, i_rdy}, {7'b0, er});
      chk("vec_o_cnt", {6'b0, o_cnt}, {6'b0, ec});
      if (ev) chk("vec_o_dat", o_dat, ed);
    end
    hs_in  = iv & m_rdy;
    hs_out = m_vld & ordy;
    hold   = rn & ~fl & m_vld & ~ordy;
    @(posedge clk);
    if (!rn || fl) begin
      q.delete();
    end else begin
      if (hs_out) void'(q.pop_front());
      if (hs_in) q.push_back(id);
    end
    last_iv    = iv;
    last_in_hs = hs_in;
    #1;
    if (en_chk && hold) begin
      chk("stall_o_vld", {7'b0, o_vld}, 8'h01);
      chk("stall_o_dat", o_dat, hdat);
    end
  endtask

  initial begin
    logic       r_iv, r_or, r_fl;
    logic [7:0] r_id;

    // Reset/idle.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);

    // Streaming 0x01..0x10 with o_rdy held high.
    for (int k = 0; k <= 16; k++) begin
      if (k == 0)
        step(1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
      else if (k < 16)
        step(1'b1, 1'b0, 1'b1, 8'(k + 1), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 8'(k));
      else
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 8'h10);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);

    // Backpressure, flush in FULL, reset in FULL.
    //           rn    fl    iv    id     ordy  ev    er    ec     ed
    tv[0]  = mk(1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    tv[1]  = mk(1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA1);
    tv[2]  = mk(1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA1);
    tv[3]  = mk(1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 2'd2, 8'hA1);
    tv[4]  = mk(1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 2'd1, 8'hA2);
    tv[5]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 8'hA3);
    tv[6]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    tv[7]  = mk(1'b1, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    tv[8]  = mk(1'b1, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 2'd1, 8'hB1);
    tv[9]  = mk(1'b1, 1'b1, 1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 2'd2, 8'hB1);
    tv[10] = mk(1'b1, 1'b0, 1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    tv[11] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 8'hB3);
    tv[12] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    tv[13] = mk(1'b1, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    tv[14] = mk(1'b1, 1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 2'd1, 8'hC1);
    tv[15] = mk(1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 2'd2, 8'hC1);
    tv[16] = mk(1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    tv[17] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 8'hC3);
    tv[18] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    for (int i = 0; i < 19; i++)
      step(tv[i].rn, tv[i].fl, tv[i].iv, tv[i].id, tv[i].ordy, 1'b1,
           1'b1, tv[i].ev, tv[i].er, tv[i].ec, tv[i].ed);

    // Random traffic; upstream holds i_vld/i_dat until accepted.
    r_iv = 1'b0;
    r_id = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      if (!(last_iv && !last_in_hs)) begin
        r_iv = ($urandom_range(0, 3) != 0);
        r_id = 8'($urandom);
      end
      r_or = ($urandom_range(0, 2) != 0) ^ (c[9] & ($urandom_range(0, 1) == 0));
      r_fl = ($urandom_range(0, 63) == 0);
      step(1'b1, r_fl, r_iv, r_id, r_or, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
